// File: rtl/sd_cmd_tx_ctrl.sv
// SD command-line transmit controller.
// Serialises a 48-bit SD command frame (start bit, direction bit, 6-bit index,
// 32-bit argument, CRC7, end bit) through an external CRC7 unit. Frame bits are
// fed into the CRC unit and the line is driven from its registered serial
// output, so the line lags the frame bit fed to the CRC unit by one cycle.
module sd_cmd_tx_ctrl #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        crc_rst,
    output logic        crc_en,
    output logic        crc_in,
    output logic        crc_shift,
    input  logic        crc_serial_in,
    output logic        cmd_out,
    output logic        cmd_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CRC,
        S_TAIL,
        S_STOP,
        S_GAP
    } state_t;

    localparam logic [5:0] GAP_LAST = (GAP_CYCLES > 0) ? 6'(GAP_CYCLES - 1) : 6'd0;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_index;
    logic [31:0] r_arg;
    logic        r_busy;
    logic        r_done;
    logic        r_crc_rst;
    logic        r_crc_en;
    logic        r_crc_in;
    logic        r_crc_shift;
    logic        r_oe;
    logic        r_sel_crc;

    // Frame bit i lives at w_frame[39-i]; w_next_sel picks bit (r_cnt+1).
    logic [39:0] w_frame;
    logic [5:0]  w_next_sel;

    assign w_frame    = {2'b01, r_index, r_arg};
    assign w_next_sel = 6'd38 - r_cnt;

    assign busy      = r_busy;
    assign done      = r_done;
    assign crc_rst   = r_crc_rst;
    assign crc_en    = r_crc_en;
    assign crc_in    = r_crc_in;
    assign crc_shift = r_crc_shift;
    assign cmd_oe    = r_oe;
    // The line follows the CRC unit's registered output; otherwise it idles high.
    assign cmd_out   = r_sel_crc ? crc_serial_in : 1'b1;

    // Frame sequencer; every output is registered for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_index     <= 6'd0;
            r_arg       <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_crc_rst   <= 1'b1;
            r_crc_en    <= 1'b0;
            r_crc_in    <= 1'b0;
            r_crc_shift <= 1'b0;
            r_oe        <= 1'b0;
            r_sel_crc   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_state   <= S_DATA;
                    r_cnt     <= 6'd0;
                    r_index   <= cmd_index;
                    r_arg     <= cmd_arg;
                    r_busy    <= 1'b1;
                    r_crc_rst <= 1'b0;
                    r_crc_en  <= 1'b1;
                    r_crc_in  <= 1'b0;
                end
            end else if (abort) begin
                r_state     <= S_IDLE;
                r_cnt       <= 6'd0;
                r_busy      <= 1'b0;
                r_crc_rst   <= 1'b1;
                r_crc_en    <= 1'b0;
                r_crc_in    <= 1'b0;
                r_crc_shift <= 1'b0;
                r_oe        <= 1'b0;
                r_sel_crc   <= 1'b0;
            end else begin
                case (r_state)
                    S_DATA: begin
                        // From DATA cycle 1 on, the line carries the previous frame bit.
                        r_oe      <= 1'b1;
                        r_sel_crc <= 1'b1;
                        if (r_cnt == 6'd39) begin
                            r_state     <= S_CRC;
                            r_cnt       <= 6'd0;
                            r_crc_en    <= 1'b0;
                            r_crc_in    <= 1'b0;
                            r_crc_shift <= 1'b1;
                        end else begin
                            r_cnt    <= r_cnt + 6'd1;
                            r_crc_in <= w_frame[w_next_sel];
                        end
                    end
                    S_CRC: begin
                        if (r_cnt == 6'd6) begin
                            r_state     <= S_TAIL;
                            r_cnt       <= 6'd0;
                            r_crc_shift <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    S_TAIL: begin
                        // End bit is a constant high, not a CRC unit output.
                        r_state   <= S_STOP;
                        r_sel_crc <= 1'b0;
                    end
                    S_STOP: begin
                        r_done    <= 1'b1;
                        r_oe      <= 1'b0;
                        r_crc_rst <= 1'b1;
                        r_cnt     <= 6'd0;
                        if (GAP_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 6'd0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_tx_ctrl.sv
// Bench for sd_cmd_tx_ctrl: two instances (GAP_CYCLES=8 and 0), each paired
// with a behavioural CRC7 unit. Expected frames are queued when a command is
// issued and compared when a full 48-bit frame has been seen on the line.
`timescale 1ns/1ps
module tb_sd_cmd_tx_ctrl;

    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance signals
    logic        start = 1'b0, abort = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        busy, done, crc_rst, crc_en, crc_in, crc_shift, cmd_out, cmd_oe;
    logic        ser = 1'b1;
    logic [6:0]  crc = '0;

    // Zero-gap instance signals
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [5:0]  idx0 = '0;
    logic [31:0] arg0 = '0;
    logic        busy0, done0, crc_rst0, crc_en0, crc_in0, crc_shift0, cmd_out0, cmd_oe0;
    logic        ser0 = 1'b1;
    logic [6:0]  crc0 = '0;

    logic [47:0] q[$];
    logic [47:0] q0[$];
    int          n_done = 0;
    bit          b2b = 1'b0;
    int          last_end = -1;

    sd_cmd_tx_ctrl #(.GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .abort(abort), .busy(busy), .done(done), .crc_rst(crc_rst), .crc_en(crc_en),
        .crc_in(crc_in), .crc_shift(crc_shift), .crc_serial_in(ser),
        .cmd_out(cmd_out), .cmd_oe(cmd_oe)
    );

    sd_cmd_tx_ctrl #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .cmd_index(idx0), .cmd_arg(arg0),
        .abort(abort0), .busy(busy0), .done(done0), .crc_rst(crc_rst0), .crc_en(crc_en0),
        .crc_in(crc_in0), .crc_shift(crc_shift0), .crc_serial_in(ser0),
        .cmd_out(cmd_out0), .cmd_oe(cmd_oe0)
    );

    // CRC7 units (x^7 + x^3 + 1) with registered serial output
    always @(posedge clk) begin
        if (crc_rst) crc <= '0;
        else if (crc_en) begin
            crc <= {crc[5:0], 1'b0} ^ ((crc_in ^ crc[6]) ? 7'h09 : 7'h00);
            ser <= crc_in;
        end else if (crc_shift) begin
            ser <= crc[6];
            crc <= {crc[5:0], 1'b0};
        end
    end

    always @(posedge clk) begin
        if (crc_rst0) crc0 <= '0;
        else if (crc_en0) begin
            crc0 <= {crc0[5:0], 1'b0} ^ ((crc_in0 ^ crc0[6]) ? 7'h09 : 7'h00);
            ser0 <= crc_in0;
        end else if (crc_shift0) begin
            ser0 <= crc0[6];
            crc0 <= {crc0[5:0], 1'b0};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] frame48(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] f;
        logic [6:0]  c;
        logic        fb;
        f = {2'b01, idx, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = f[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {f, c, 1'b1};
    endfunction

    // Line monitor, main instance
    initial begin
        logic [47:0] bits;
        int          n;
        int          spec;
        bits = '0;
        n = 0;
        forever begin
            @(negedge clk);
            spec = cyc + 1;
            check("crc_en_shift_excl", {62'd0, crc_en & crc_shift, (crc_en | crc_shift) & crc_rst}, 64'd0);
            if (done) n_done++;
            if (cmd_oe) begin
                if (n == 0 && b2b && last_end >= 0)
                    check("b2b_idle_cycles", 64'(spec - last_end - 1), 64'(GAP + 2));
                bits = {bits[46:0], cmd_out};
                n++;
                if (n == 48) begin
                    if (q.size() == 0) check("unexpected_frame", {16'd0, bits}, 64'd0);
                    else check("frame", {16'd0, bits}, {16'd0, q.pop_front()});
                    last_end = spec;
                    n = 0;
                end
            end else begin
                n = 0;
            end
        end
    end

    // Line monitor, zero-gap instance
    initial begin
        logic [47:0] bits;
        int          n;
        bits = '0;
        n = 0;
        forever begin
            @(negedge clk);
            check("crc_en_shift_excl0", {62'd0, crc_en0 & crc_shift0, (crc_en0 | crc_shift0) & crc_rst0}, 64'd0);
            if (cmd_oe0) begin
                bits = {bits[46:0], cmd_out0};
                n++;
                if (n == 48) begin
                    if (q0.size() == 0) check("unexpected_frame0", {16'd0, bits}, 64'd0);
                    else check("frame0", {16'd0, bits}, {16'd0, q0.pop_front()});
                    n = 0;
                end
            end else begin
                n = 0;
            end
        end
    end

    task automatic wait_busy(input logic lvl, input string tag);
        int k;
        k = 0;
        while (busy !== lvl && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check(tag, 64'd1, 64'd0);
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp);
        int t, first, dn;
        @(negedge clk);
        wait_busy(1'b0, "idle_timeout");
        cmd_index = idx;
        cmd_arg   = arg;
        start     = 1'b1;
        q.push_back(exp);
        @(posedge clk);
        #1;
        t = cyc;
        start = 1'b0;
        first = -1;
        dn = -1;
        for (int k = 0; k < 80 && dn < 0; k++) begin
            @(negedge clk);
            if (cmd_oe && first < 0) first = cyc + 1;
            if (done) dn = cyc + 1;
        end
        check("first_bit_latency", 64'(first - t), 64'd2);
        check("done_latency", 64'(dn - t), 64'd50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, nd;
        logic [5:0]  ri;
        logic [31:0] ra;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", cmd_oe, 0);
        check("rst_out", cmd_out, 1);
        check("rst_crc_en", crc_en, 0);
        check("rst_crc_shift", crc_shift, 0);
        check("rst_crc_rst", crc_rst, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_crc_rst", crc_rst, 1);
        check("idle_out", cmd_out, 1);

        // Known frames plus random ones
        send(6'd0, 32'h0, 48'h400000000095);
        send(6'd17, 32'h0, 48'h510000000055);
        send(6'd8, 32'h000001AA, 48'h48000001AA87);
        for (int i = 0; i < 3; i++) begin
            ri = 6'($urandom_range(0, 63));
            ra = $urandom;
            send(ri, ra, frame48(ri, ra));
        end

        // Back-to-back with start held high throughout
        @(negedge clk);
        wait_busy(1'b0, "b2b_idle_timeout");
        b2b = 1'b1;
        last_end = -1;
        cmd_index = 6'd55;
        cmd_arg = 32'hDEADBEEF;
        q.push_back(frame48(6'd55, 32'hDEADBEEF));
        start = 1'b1;
        wait_busy(1'b1, "b2b_accept1");
        cmd_index = 6'd12;
        cmd_arg = 32'h0F0F1234;
        q.push_back(frame48(6'd12, 32'h0F0F1234));
        wait_busy(1'b0, "b2b_release1");
        wait_busy(1'b1, "b2b_accept2");
        start = 1'b0;
        @(negedge clk);
        wait_busy(1'b0, "b2b_release2");
        b2b = 1'b0;

        // Abort in CRC cycle 3
        nd = n_done;
        cmd_index = 6'd17;
        cmd_arg = 32'h12345678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (43) @(posedge clk);
        #1;
        check("pre_abort_oe", cmd_oe, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_oe", cmd_oe, 0);
        check("abort_busy", busy, 0);
        repeat (60) @(negedge clk);
        check("abort_no_done", 64'(n_done - nd), 64'd0);
        send(6'd0, 32'h0, 48'h400000000095);

        // Reset in DATA cycle 20
        @(negedge clk);
        wait_busy(1'b0, "rst_idle_timeout");
        nd = n_done;
        cmd_index = 6'd8;
        cmd_arg = 32'h000001AA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_oe", cmd_oe, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_oe", cmd_oe, 0);
        check("rst_async_out", cmd_out, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_done", 64'(n_done - nd), 64'd0);
        send(6'd8, 32'h000001AA, 48'h48000001AA87);

        // Zero-gap instance: done lands in IDLE and a held start is taken there
        @(negedge clk);
        idx0 = 6'd8;
        arg0 = 32'h000001AA;
        q0.push_back(48'h48000001AA87);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        idx0 = 6'd0;
        arg0 = 32'h0;
        q0.push_back(48'h400000000095);
        nd = -1;
        for (int k = 0; k < 80 && nd < 0; k++) begin
            @(negedge clk);
            if (done0) begin
                nd = cyc + 1;
                check("gap0_done_in_idle", busy0, 0);
            end
        end
        check("gap0_done_latency", 64'(nd - t), 64'd50);
        @(negedge clk);
        check("gap0_restart", busy0, 1);
        start0 = 1'b0;
        nd = -1;
        for (int k = 0; k < 80 && nd < 0; k++) begin
            @(negedge clk);
            if (done0) nd = cyc + 1;
        end
        check("gap0_second_done", {63'd0, nd > 0}, 64'd1);

        repeat (20) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("queue0_empty", 64'(q0.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
